booth_controller: RTL and testbench

//   FSM control unit for the Booth multiplier datapath. Sequences the load, add/subtract, arithmetic-shift and count-down

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_controller.sv | 145 ++++++++++++++
 tb/tb_booth_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier control path: state encoding,
// ALU operation codes and the default operand width.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/booth_controller.sv
// Booth multiplier control FSM: sequences load / add-sub / shift / count-down
// from datapath flags, with a start/done handshake and a watchdog-driven error state.
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int WDOG_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
  output logic LdA,
  output logic LdQ,
  output logic LdM,
  output logic clrA,
  output logic clrQ,
  output logic clrM,
  output logic clrff,
  output logic sftA,
  output logic sftQ,
  output logic sftDff,
  output logic add_sub,
  output logic EnableALU,
  output logic LdCount,
  output logic decr,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [WDOG_W-1:0] WdogMax = '1;

  // A healthy multiply (LOAD + WIDTH loop pairs + final EVAL) must finish before the watchdog fires.
  if (2 * WIDTH + 2 >= 2 ** WDOG_W - 1) begin : gWdogCheck
    $error("booth_controller: watchdog too short for WIDTH");
  end

  state_t            state;
  state_t            nextState;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdogInc;
  logic              wdogHit;
  logic              counting;

  assign wdogInc  = wdog + 1'b1;
  assign counting = (state == LOAD) || (state == EVAL) || (state == SHIFT);
  // Fires on the cycle the counter reaches its ceiling, so ERR follows on the next edge.
  assign wdogHit  = counting && (wdogInc == WdogMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        wdog <= '0;
      end else if (counting) begin
        wdog <= wdogInc;
      end
    end
  end

  always_comb begin
    nextState = state;
    LdA       = 1'b0;
    LdQ       = 1'b0;
    LdM       = 1'b0;
    clrA      = 1'b0;
    clrQ      = 1'b0;
    clrM      = 1'b0;
    clrff     = 1'b0;
    sftA      = 1'b0;
    sftQ      = 1'b0;
    sftDff    = 1'b0;
    add_sub   = ADD;
    EnableALU = 1'b0;
    LdCount   = 1'b0;
    decr      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state)
      IDLE: begin
        if (start) nextState = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        LdM       = 1'b1;
        LdQ       = 1'b1;
        LdCount   = 1'b1;
        clrA      = 1'b1;
        clrff     = 1'b1;
        nextState = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (eqz) begin
          nextState = DONE;
        end else begin
          case ({q0, qm1})
            2'b10: begin
              EnableALU = 1'b1;
              LdA       = 1'b1;
              add_sub   = SUB;
            end
            2'b01: begin
              EnableALU = 1'b1;
              LdA       = 1'b1;
              add_sub   = ADD;
            end
            default: ;
          endcase
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        sftA      = 1'b1;
        sftQ      = 1'b1;
        sftDff    = 1'b1;
        decr      = 1'b1;
        nextState = EVAL;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        // Requester must drop start before another multiply can launch.
        if (!start) nextState = IDLE;
      end
      ERR: begin
        busy = 1'b1;
        err  = 1'b1;
      end
      default: nextState = IDLE;
    endcase

    if (wdogHit) nextState = ERR;
  end

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller driving a small behavioural Booth datapath,
// checking products, handshake timing, abort, zero-iteration and watchdog behaviour.
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic q0, qm1, eqz;
  logic LdA, LdQ, LdM, clrA, clrQ, clrM, clrff, sftA, sftQ, sftDff;
  logic add_sub, EnableALU, LdCount, decr, busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  bit monEn = 1'b0;
  logic [1:0] forceMode = 2'd0;  // 0: datapath eqz, 1: eqz stuck 0, 2: eqz stuck 1

  // Behavioural datapath; A carries one guard bit so -128 * -128 stays representable.
  logic [8:0] accA = '0;
  logic [7:0] regQ = '0;
  logic [7:0] regM = '0;
  logic       regQm1 = 1'b0;
  logic [3:0] cnt = '0;
  logic [7:0] mIn = '0;
  logic [7:0] qIn = '0;
  logic [16:0] allOut;

  booth_controller #(.WIDTH(8), .WDOG_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .qm1(qm1), .eqz(eqz),
    .LdA(LdA), .LdQ(LdQ), .LdM(LdM), .clrA(clrA), .clrQ(clrQ), .clrM(clrM),
    .clrff(clrff), .sftA(sftA), .sftQ(sftQ), .sftDff(sftDff), .add_sub(add_sub),
    .EnableALU(EnableALU), .LdCount(LdCount), .decr(decr), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign q0  = regQ[0];
  assign qm1 = regQm1;
  assign eqz = (forceMode == 2'd0) ? (cnt == 4'd0) : (forceMode == 2'd2);
  assign allOut = {LdA, LdQ, LdM, clrA, clrQ, clrM, clrff, sftA, sftQ, sftDff,
                   add_sub, EnableALU, LdCount, decr, busy, done, err};

  always @(posedge clk) begin
    if (clrA) accA <= '0;
    else if (LdA) accA <= add_sub ? accA - {regM[7], regM} : accA + {regM[7], regM};
    else if (sftA) accA <= {accA[8], accA[8:1]};
    if (clrQ) regQ <= '0;
    else if (LdQ) regQ <= qIn;
    else if (sftQ) regQ <= {accA[0], regQ[7:1]};
    if (clrM) regM <= '0;
    else if (LdM) regM <= mIn;
    if (clrff) regQm1 <= 1'b0;
    else if (sftDff) regQm1 <= regQ[0];
    if (LdCount) cnt <= 4'd8;
    else if (decr) cnt <= cnt - 4'd1;
  end

  // Strobe-group exclusivity and pairing, every cycle once enabled.
  always @(negedge clk) begin
    if (monEn) begin
      int grpLoad, grpEval, grpShift;
      grpLoad  = int'(LdM | LdQ | LdCount | clrA | clrff);
      grpEval  = int'(LdA | EnableALU | add_sub);
      grpShift = int'(sftA | sftQ | sftDff | decr);
      vectors++;
      if ((grpLoad + grpEval + grpShift > 1) || (LdA && !EnableALU) || (decr !== sftA)) begin
        miscompares++;
        $display("FAIL strobe_invariant at %0t: load=%0d eval=%0d shift=%0d LdA=%b EnableALU=%b decr=%b sftA=%b",
                 $time, grpLoad, grpEval, grpShift, LdA, EnableALU, decr, sftA);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doOp(input logic [7:0] m, input logic [7:0] q, input bit hold,
                      output int doneCyc, output logic [15:0] prod,
                      output int nAdd, output int nSub, output int nBusy);
    mIn = m; qIn = q; start = 1'b1;
    doneCyc = -1; prod = 'x; nAdd = 0; nSub = 0; nBusy = 0;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        doneCyc = c;
        prod = {accA[7:0], regQ};
        break;
      end
      if (busy) nBusy++;
      if (LdA && add_sub) nSub++;
      if (LdA && !add_sub) nAdd++;
      tick();
    end
  endtask

  task automatic releaseOp();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    vectors++;
    if (allOut !== 17'h0) begin
      miscompares++; $display("FAIL reset_outputs: got %h, expected %h", allOut, 17'h0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if (allOut !== 17'h0) begin
      miscompares++; $display("FAIL reset_idle_outputs: got %h, expected %h", allOut, 17'h0);
    end
  endtask

  task automatic test_basic();
    int dc, na, ns, nb; logic [15:0] p;
    doOp(8'd3, 8'd5, 1'b0, dc, p, na, ns, nb);
    vectors++; if (dc !== 19) begin miscompares++; $display("FAIL basic_done_cycle: got %0d, expected 19", dc); end
    vectors++; if (p !== 16'h000F) begin miscompares++; $display("FAIL basic_product: got %h, expected 000f", p); end
    vectors++; if (nb !== 18) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d, expected 18", nb); end
    vectors++; if (ns !== 2 || na !== 2) begin miscompares++; $display("FAIL basic_alu_count: sub %0d add %0d, expected 2 and 2", ns, na); end
    releaseOp();
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL basic_return_idle: busy %b done %b, expected 0 0", busy, done); end
  endtask

  task automatic test_negative();
    int dc, na, ns, nb; logic [15:0] p;
    doOp(8'hF9, 8'h06, 1'b0, dc, p, na, ns, nb);
    vectors++; if (dc !== 19) begin miscompares++; $display("FAIL neg_done_cycle: got %0d, expected 19", dc); end
    vectors++; if (p !== 16'hFFD6) begin miscompares++; $display("FAIL neg_product: got %h, expected ffd6", p); end
    vectors++; if (ns !== 1 || na !== 1) begin miscompares++; $display("FAIL neg_alu_count: sub %0d add %0d, expected 1 and 1", ns, na); end
    releaseOp();
  endtask

  task automatic test_hold_start();
    int dc, na, ns, nb, lowDone, loads; logic [15:0] p;
    doOp(8'h80, 8'h80, 1'b1, dc, p, na, ns, nb);
    vectors++; if (dc !== 19) begin miscompares++; $display("FAIL hold_done_cycle: got %0d, expected 19", dc); end
    vectors++; if (p !== 16'h4000) begin miscompares++; $display("FAIL hold_product: got %h, expected 4000", p); end
    lowDone = 0; loads = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!done) lowDone++;
      if (LdM || LdQ) loads++;
    end
    vectors++; if (lowDone !== 0) begin miscompares++; $display("FAIL hold_done_held: done low %0d cycles, expected 0", lowDone); end
    vectors++; if (loads !== 0) begin miscompares++; $display("FAIL hold_no_relaunch: %0d load pulses, expected 0", loads); end
    releaseOp();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL hold_release: done %b busy %b, expected 0 0", done, busy); end
  endtask

  task automatic test_reset_abort();
    int dc, na, ns, nb; logic [15:0] p;
    mIn = 8'd2; qIn = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (allOut !== 17'h0) begin miscompares++; $display("FAIL abort_outputs: got %h, expected %h", allOut, 17'h0); end
    tick();
    vectors++; if (allOut !== 17'h0) begin miscompares++; $display("FAIL abort_stays_idle: got %h, expected %h", allOut, 17'h0); end
    doOp(8'd2, 8'd9, 1'b0, dc, p, na, ns, nb);
    vectors++; if (dc !== 19) begin miscompares++; $display("FAIL abort_restart_cycle: got %0d, expected 19", dc); end
    vectors++; if (p !== 16'h0012) begin miscompares++; $display("FAIL abort_restart_product: got %h, expected 0012", p); end
    releaseOp();
  endtask

  task automatic test_back_to_back();
    int dc, na, ns, nb; logic [15:0] p;
    doOp(8'd5, 8'hFD, 1'b0, dc, p, na, ns, nb);
    vectors++; if (p !== 16'hFFF1) begin miscompares++; $display("FAIL b2b_first_product: got %h, expected fff1", p); end
    releaseOp();
    doOp(8'hFF, 8'hFF, 1'b0, dc, p, na, ns, nb);
    vectors++; if (dc !== 19) begin miscompares++; $display("FAIL b2b_second_cycle: got %0d, expected 19", dc); end
    vectors++; if (p !== 16'h0001) begin miscompares++; $display("FAIL b2b_second_product: got %h, expected 0001", p); end
    releaseOp();
  endtask

  task automatic test_zero_iter();
    int dc, na, ns, nb; logic [15:0] p;
    forceMode = 2'd2;
    doOp(8'd7, 8'd7, 1'b0, dc, p, na, ns, nb);
    vectors++; if (dc !== 3) begin miscompares++; $display("FAIL zero_iter_cycle: got %0d, expected 3", dc); end
    vectors++; if (na + ns !== 0) begin miscompares++; $display("FAIL zero_iter_alu: got %0d strobes, expected 0", na + ns); end
    vectors++; if (nb !== 2) begin miscompares++; $display("FAIL zero_iter_busy: got %0d, expected 2", nb); end
    releaseOp();
    forceMode = 2'd0;
  endtask

  task automatic test_watchdog();
    int errCyc, sawDone, errLow;
    forceMode = 2'd1;
    mIn = 8'd3; qIn = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    errCyc = -1; sawDone = 0;
    for (int c = 1; c <= 200; c++) begin
      if (err) begin errCyc = c; break; end
      if (done) sawDone++;
      tick();
    end
    vectors++; if (errCyc !== 64) begin miscompares++; $display("FAIL wdog_err_cycle: got %0d, expected 64", errCyc); end
    vectors++; if (sawDone !== 0) begin miscompares++; $display("FAIL wdog_no_done: done high %0d cycles, expected 0", sawDone); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wdog_busy: got %b, expected 1", busy); end
    errLow = 0;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      tick();
      if (!err || done) errLow++;
    end
    vectors++; if (errLow !== 0) begin miscompares++; $display("FAIL wdog_sticky: %0d bad cycles, expected 0", errLow); end
    start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (allOut !== 17'h0) begin miscompares++; $display("FAIL wdog_rst_clears: got %h, expected %h", allOut, 17'h0); end
    forceMode = 2'd0;
  endtask

  initial begin
    #1;
    test_reset();
    monEn = 1'b1;
    test_basic();
    test_negative();
    test_hold_start();
    test_reset_abort();
    test_back_to_back();
    test_zero_iter();
    test_watchdog();
    monEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
